wb_slave_mux: RTL and testbench
===============================

// Module: wb_slave_mux
// PURPOSE
//  Parametrised Wishbone (pipelined) address decoder/mux between one core master and NUM_SLAVES slaves.
//  Replaces the wired-OR shared wb_idat/wb_ack net in the SoC top: per-slave stb/cyc, muxed read data/ack.
//  Adds bus-error response for unmapped addresses and a watchdog timeout for hung slaves.
//  Single outstanding transaction; request registered once, held until the slave acks, errors or is aborted.
// PARAMETERS
//  NUM_SLAVES     4                        number of slave ports (1..16)
//  ADDR_W         64                       address width
//  DATA_W         64                       data width; SEL_W = DATA_W/8
//  SLAVE_BASE     {NUM_SLAVES*ADDR_W}      packed base addresses, slave i at [i*ADDR_W +: ADDR_W]
//  SLAVE_MASK     {NUM_SLAVES*ADDR_W}      packed masks; hit_i = ((adr & MASK_i) == BASE_i)
//  TIMEOUT_CYCLES 255                      max cycles in REQ+WAIT before bus error (>=2)
// PORTS
//  i_clk       in   1               core clock
//  i_reset     in   1               async reset, active-high
//  i_wb_adr    in   ADDR_W          master address
//  i_wb_dat    in   DATA_W          master write data
//  o_wb_dat    out  DATA_W          read data to master, valid with o_wb_ack
//  i_wb_we     in   1               write enable
//  i_wb_sel    in   SEL_W           byte selects
//  i_wb_stb    in   1               strobe
//  i_wb_cyc    in   1               cycle
//  o_wb_ack    out  1               ack pulse
//  o_wb_err    out  1               error pulse (unmapped or timeout)
//  o_wb_stall  out  1               request not accepted
//  o_s_adr     out  ADDR_W          latched address to all slaves
//  o_s_dat     out  DATA_W          latched write data to all slaves
//  o_s_we      out  1               latched we
//  o_s_sel     out  SEL_W           latched sel
//  o_s_cyc     out  NUM_SLAVES      one-hot cyc to selected slave
//  o_s_stb     out  NUM_SLAVES      one-hot stb to selected slave
//  i_s_dat     in   NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
//  i_s_ack     in   NUM_SLAVES      slave acks
//  i_s_stall   in   NUM_SLAVES      slave stalls
//  o_err_adr   out  ADDR_W          address of most recent errored request
//  o_err_count out  8               errors since reset, saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (o_wb_dat, o_s_*, o_err_adr, o_err_count, timer = 0).
//  o_wb_stall = (state != IDLE). Slave-side acks/stalls of non-selected slaves are ignored.
//  Decode: lowest-index hit wins when several slaves match; no hit -> miss.
//  IDLE: on i_wb_cyc & i_wb_stb: latch adr/dat/we/sel, latch slave index; hit -> REQ, miss -> ERR.
//  REQ: o_s_cyc[idx]=o_s_stb[idx]=1. If !i_s_stall[idx] -> WAIT (stb drops next cycle, cyc held).
//   i_s_ack[idx] sampled in REQ with stall low counts as completion (go DONE directly).
//  WAIT: o_s_cyc[idx]=1, stb=0; on i_s_ack[idx] -> DONE, o_wb_dat <= i_s_dat[idx] same edge.
//  DONE: o_wb_ack=1 for exactly one cycle, slave cyc=0; -> IDLE. Next request accepted in IDLE.
//  ERR: o_wb_err=1 one cycle, o_wb_dat=0, o_err_adr<=latched adr, o_err_count++ (sat); -> IDLE.
//  Timeout: counter clears on IDLE->REQ, increments each cycle in REQ/WAIT; at TIMEOUT_CYCLES
//   without ack -> ERR (slave cyc/stb dropped same edge). Ack on the timeout cycle wins (DONE).
//  Abort: i_wb_cyc low in REQ/WAIT -> IDLE next edge, slave cyc/stb dropped, no ack/err issued.
//  o_wb_ack and o_wb_err never both high; at most one response per accepted request.
//  Latency (zero-wait slave acking 1 cycle after stb): accept C0, stb C1, s_ack C2, o_wb_ack C3.
//  Async reset mid-transaction: all outputs 0 immediately; no response issued for the lost request.
// TESTING
//  Read slave 1 (BASE 0x1_0000_0000, MASK ~0xFFF), s_dat=0xDEADBEEF, 0-wait -> o_wb_ack at C3, o_wb_dat=0xDEADBEEF.
//  Write 0x55 sel=0x01 to slave 2 with i_s_stall high 3 cycles -> s_stb held 4 cycles, one ack, o_s_dat=0x55.
//  Access adr 0x2_0000_0000 (no hit) -> o_wb_err 1 cycle 2 cycles after accept, o_err_adr=0x2_0000_0000, count=1.
//  Slave never acks, TIMEOUT_CYCLES=8 -> o_wb_err after 8 cycles in REQ/WAIT, o_s_cyc=0, no ack.
//  Overlapping masks slaves 0 and 3 both hit -> only o_s_stb[0] asserted; ack on stray i_s_ack[3] ignored.
//  Drop i_wb_cyc in WAIT, then i_s_ack -> no o_wb_ack; 256 errors -> o_err_count stays 255.

Source files
------------

// File: rtl/wb_slave_mux.sv
// Pipelined Wishbone decoder/mux: one master, NUM_SLAVES slaves, one outstanding request.
// Unmapped addresses and hung slaves are answered with a bus-error pulse.
module wb_slave_mux #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {
    64'h0000_0003_0000_0000, 64'h0000_0002_0000_0000,
    64'h0000_0001_0000_0000, 64'h0000_0000_0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {
    64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000,
    64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000},
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SEL_W = DATA_W / 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [ADDR_W-1:0]        i_wb_adr,
  input  logic [DATA_W-1:0]        i_wb_dat,
  output logic [DATA_W-1:0]        o_wb_dat,
  input  logic                     i_wb_we,
  input  logic [SEL_W-1:0]         i_wb_sel,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_cyc,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic                     o_wb_stall,
  output logic [ADDR_W-1:0]        o_s_adr,
  output logic [DATA_W-1:0]        o_s_dat,
  output logic                     o_s_we,
  output logic [SEL_W-1:0]         o_s_sel,
  output logic [NUM_SLAVES-1:0]    o_s_cyc,
  output logic [NUM_SLAVES-1:0]    o_s_stb,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_s_dat,
  input  logic [NUM_SLAVES-1:0]    i_s_ack,
  input  logic [NUM_SLAVES-1:0]    i_s_stall,
  output logic [ADDR_W-1:0]        o_err_adr,
  output logic [7:0]               o_err_count
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [TMR_W-1:0]        timer_q;
  logic [ADDR_W-1:0]       s_adr_q;
  logic [DATA_W-1:0]       s_dat_q;
  logic                    s_we_q;
  logic [SEL_W-1:0]        s_sel_q;
  logic [NUM_SLAVES-1:0]   s_cyc_q;
  logic [NUM_SLAVES-1:0]   s_stb_q;
  logic [DATA_W-1:0]       wb_dat_q;
  logic                    ack_q;
  logic                    err_q;
  logic [ADDR_W-1:0]       err_adr_q;
  logic [7:0]              err_cnt_q;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic [DATA_W-1:0]       sel_dat;
  logic                    sel_ack;
  logic                    sel_stall;
  logic                    timeout;

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_wb_adr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
    dec_onehot = NUM_SLAVES'(1) << dec_idx;
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) sel_dat = i_s_dat[i*DATA_W +: DATA_W];
    end
    sel_ack   = i_s_ack[idx_q];
    sel_stall = i_s_stall[idx_q];
    timeout   = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      timer_q   <= '0;
      s_adr_q   <= '0;
      s_dat_q   <= '0;
      s_we_q    <= 1'b0;
      s_sel_q   <= '0;
      s_cyc_q   <= '0;
      s_stb_q   <= '0;
      wb_dat_q  <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_wb_cyc && i_wb_stb) begin
            s_adr_q <= i_wb_adr;
            s_dat_q <= i_wb_dat;
            s_we_q  <= i_wb_we;
            s_sel_q <= i_wb_sel;
            idx_q   <= dec_idx;
            timer_q <= '0;
            if (dec_hit) begin
              state_q <= StReq;
              s_cyc_q <= dec_onehot;
              s_stb_q <= dec_onehot;
            end else begin
              state_q <= StErr;
            end
          end
        end
        StReq, StWait: begin
          // Priority: abort, then completion (wins over a same-cycle timeout), then timeout.
          if (!i_wb_cyc) begin
            state_q <= StIdle;
            s_cyc_q <= '0;
            s_stb_q <= '0;
          end else if (sel_ack && (state_q == StWait || !sel_stall)) begin
            state_q  <= StDone;
            wb_dat_q <= sel_dat;
            ack_q    <= 1'b1;
            s_cyc_q  <= '0;
            s_stb_q  <= '0;
          end else if (timeout) begin
            state_q <= StErr;
            s_cyc_q <= '0;
            s_stb_q <= '0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (state_q == StReq && !sel_stall) begin
              state_q <= StWait;
              s_stb_q <= '0;
            end
          end
        end
        StDone: state_q <= StIdle;
        StErr: begin
          state_q   <= StIdle;
          err_q     <= 1'b1;
          wb_dat_q  <= '0;
          err_adr_q <= s_adr_q;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_wb_dat    = wb_dat_q;
  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_wb_stall  = (state_q != StIdle);
  assign o_s_adr     = s_adr_q;
  assign o_s_dat     = s_dat_q;
  assign o_s_we      = s_we_q;
  assign o_s_sel     = s_sel_q;
  assign o_s_cyc     = s_cyc_q;
  assign o_s_stb     = s_stb_q;
  assign o_err_adr   = err_adr_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux: reads, stalled write, misses, timeout, overlap, abort, reset.
module tb_wb_slave_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;
  localparam logic [N*AW-1:0] BASE = {64'h0, 64'h3_0000_0000, 64'h1_0000_0000, 64'h0};
  localparam logic [N*AW-1:0] MASK = {~64'hFF, ~64'hFFF, ~64'hFFF, ~64'hFFF};

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   wb_adr = '0;
  logic [DW-1:0]   wb_dat_w = '0;
  logic [DW-1:0]   wb_dat_r;
  logic            wb_we = 1'b0;
  logic [SW-1:0]   wb_sel = '0;
  logic            wb_stb = 1'b0;
  logic            wb_cyc = 1'b0;
  logic            wb_ack, wb_err, wb_stall;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic            s_we;
  logic [SW-1:0]   s_sel;
  logic [N-1:0]    s_cyc, s_stb;
  logic [N*DW-1:0] s_dat_r = '0;
  logic [N-1:0]    s_ack = '0;
  logic [N-1:0]    s_stall = '0;
  logic [AW-1:0]   err_adr;
  logic [7:0]      err_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_slave_mux #(
    .NUM_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat_w), .o_wb_dat(wb_dat_r),
    .i_wb_we(wb_we), .i_wb_sel(wb_sel), .i_wb_stb(wb_stb), .i_wb_cyc(wb_cyc),
    .o_wb_ack(wb_ack), .o_wb_err(wb_err), .o_wb_stall(wb_stall),
    .o_s_adr(s_adr), .o_s_dat(s_dat_w), .o_s_we(s_we), .o_s_sel(s_sel),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb),
    .i_s_dat(s_dat_r), .i_s_ack(s_ack), .i_s_stall(s_stall),
    .o_err_adr(err_adr), .o_err_count(err_count)
  );

  // Present a request at a negedge; the following posedge accepts it.
  task automatic issue(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel);
    wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_sel = sel;
    wb_cyc = 1'b1; wb_stb = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({wb_ack, wb_err, wb_stall, s_cyc, s_stb} !== '0) begin
      bad++; $display("FAIL reset_ctl got=%0h exp=0", {wb_ack, wb_err, wb_stall, s_cyc, s_stb});
    end
    total++;
    if ({wb_dat_r, s_adr, s_dat_w, err_adr, err_count} !== '0) begin
      bad++; $display("FAIL reset_data got=nonzero exp=0");
    end
    rst = 1'b0;
  endtask

  task automatic test_read;
    @(negedge clk);
    issue(64'h1_0000_0008, 1'b0, '0, 8'hFF);
    @(negedge clk);                        // C1
    total++;
    if (s_stb !== 4'b0010 || wb_stall !== 1'b1) begin
      bad++; $display("FAIL read_stb got=%b/%b exp=0010/1", s_stb, wb_stall);
    end
    wb_stb = 1'b0;
    @(negedge clk);                        // C2
    total++;
    if (s_stb !== 4'b0000 || s_cyc !== 4'b0010) begin
      bad++; $display("FAIL read_wait got=%b/%b exp=0000/0010", s_stb, s_cyc);
    end
    s_ack = 4'b0010;
    s_dat_r[1*DW +: DW] = 64'hDEADBEEF;
    @(negedge clk);                        // C3
    total++;
    if (wb_ack !== 1'b1 || wb_dat_r !== 64'hDEADBEEF || s_cyc !== 4'b0000) begin
      bad++; $display("FAIL read_ack got=%b/%0h/%b exp=1/deadbeef/0000", wb_ack, wb_dat_r, s_cyc);
    end
    s_ack = '0;
    @(negedge clk);
    total++;
    if (wb_ack !== 1'b0 || wb_stall !== 1'b0) begin
      bad++; $display("FAIL read_after got=%b/%b exp=0/0", wb_ack, wb_stall);
    end
    wb_cyc = 1'b0;
  endtask

  task automatic test_stall_write;
    int acks = 0;
    @(negedge clk);
    issue(64'h3_0000_0010, 1'b1, 64'h55, 8'h01);
    s_stall = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wb_stb = 1'b0;
      total++;
      if (s_stb !== 4'b0100 || s_dat_w !== 64'h55 || s_we !== 1'b1 || s_sel !== 8'h01) begin
        bad++; $display("FAIL wr_stb%0d got=%b/%0h/%b/%0h exp=0100/55/1/01", k, s_stb, s_dat_w,
                        s_we, s_sel);
      end
      if (k == 3) s_stall = '0;
    end
    @(negedge clk);
    total++;
    if (s_stb !== 4'b0000 || s_cyc !== 4'b0100) begin
      bad++; $display("FAIL wr_wait got=%b/%b exp=0000/0100", s_stb, s_cyc);
    end
    s_ack = 4'b0100;
    @(negedge clk);
    s_ack = '0;
    if (wb_ack) acks++;
    repeat (3) begin
      @(negedge clk);
      if (wb_ack) acks++;
    end
    total++;
    if (acks != 1) begin
      bad++; $display("FAIL wr_acks got=%0d exp=1", acks);
    end
    wb_cyc = 1'b0;
  endtask

  task automatic test_miss;
    @(negedge clk);
    issue(64'h2_0000_0000, 1'b0, '0, 8'hFF);
    @(negedge clk);                        // C1
    wb_cyc = 1'b0; wb_stb = 1'b0;
    total++;
    if (wb_err !== 1'b0 || wb_stall !== 1'b1 || s_cyc !== '0) begin
      bad++; $display("FAIL miss_c1 got=%b/%b/%b exp=0/1/0000", wb_err, wb_stall, s_cyc);
    end
    @(negedge clk);                        // C2
    total++;
    if (wb_err !== 1'b1 || wb_ack !== 1'b0 || wb_dat_r !== '0) begin
      bad++; $display("FAIL miss_err got=%b/%b/%0h exp=1/0/0", wb_err, wb_ack, wb_dat_r);
    end
    total++;
    if (err_adr !== 64'h2_0000_0000 || err_count !== 8'd1) begin
      bad++; $display("FAIL miss_log got=%0h/%0d exp=200000000/1", err_adr, err_count);
    end
    @(negedge clk);
    total++;
    if (wb_err !== 1'b0) begin
      bad++; $display("FAIL miss_pulse got=%b exp=0", wb_err);
    end
  endtask

  task automatic test_timeout;
    int acks = 0;
    @(negedge clk);
    issue(64'h100, 1'b0, '0, 8'hFF);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      wb_stb = 1'b0;
      if (wb_ack) acks++;
      total++;
      if (s_cyc !== 4'b0001 || wb_err !== 1'b0) begin
        bad++; $display("FAIL to_hold%0d got=%b/%b exp=0001/0", k, s_cyc, wb_err);
      end
    end
    @(negedge clk);                        // C9: ERR state
    total++;
    if (s_cyc !== 4'b0000 || s_stb !== 4'b0000 || wb_err !== 1'b0) begin
      bad++; $display("FAIL to_drop got=%b/%b/%b exp=0000/0000/0", s_cyc, s_stb, wb_err);
    end
    @(negedge clk);                        // C10
    if (wb_ack) acks++;
    total++;
    if (wb_err !== 1'b1 || err_count !== 8'd2 || err_adr !== 64'h100 || acks != 0) begin
      bad++; $display("FAIL to_err got=%b/%0d/%0h/%0d exp=1/2/100/0", wb_err, err_count, err_adr,
                      acks);
    end
    wb_cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overlap;
    @(negedge clk);
    issue(64'h10, 1'b0, '0, 8'hFF);
    s_dat_r[0*DW +: DW] = 64'h1234;
    s_dat_r[3*DW +: DW] = 64'hBAD;
    @(negedge clk);
    wb_stb = 1'b0;
    total++;
    if (s_stb !== 4'b0001) begin
      bad++; $display("FAIL ovl_stb got=%b exp=0001", s_stb);
    end
    s_ack = 4'b1000;
    @(negedge clk);
    total++;
    if (wb_ack !== 1'b0 || s_cyc !== 4'b0001) begin
      bad++; $display("FAIL ovl_stray got=%b/%b exp=0/0001", wb_ack, s_cyc);
    end
    s_ack = 4'b0001;
    @(negedge clk);
    s_ack = '0;
    total++;
    if (wb_ack !== 1'b1 || wb_dat_r !== 64'h1234) begin
      bad++; $display("FAIL ovl_ack got=%b/%0h exp=1/1234", wb_ack, wb_dat_r);
    end
    wb_cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int resp = 0;
    @(negedge clk);
    issue(64'h1_0000_0040, 1'b0, '0, 8'hFF);
    @(negedge clk);
    wb_stb = 1'b0;
    @(negedge clk);                        // in WAIT
    wb_cyc = 1'b0;
    @(negedge clk);
    total++;
    if (s_cyc !== 4'b0000 || wb_stall !== 1'b0) begin
      bad++; $display("FAIL abort_drop got=%b/%b exp=0000/0", s_cyc, wb_stall);
    end
    s_ack = 4'b0010;
    repeat (4) begin
      @(negedge clk);
      if (wb_ack || wb_err) resp++;
    end
    s_ack = '0;
    total++;
    if (resp != 0) begin
      bad++; $display("FAIL abort_resp got=%0d exp=0", resp);
    end
  endtask

  task automatic test_saturate;
    // Two errors already logged; 253 more reach 255, then 5 more must not wrap.
    for (int k = 0; k < 258; k++) begin
      @(negedge clk);
      issue(64'h2_0000_0000 + 64'(k), 1'b0, '0, 8'hFF);
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clk);
      if (k == 252) begin
        total++;
        if (err_count !== 8'd255) begin
          bad++; $display("FAIL sat_reach got=%0d exp=255", err_count);
        end
      end
    end
    total++;
    if (err_count !== 8'd255 || err_adr !== 64'h2_0000_0101) begin
      bad++; $display("FAIL sat_hold got=%0d/%0h exp=255/200000101", err_count, err_adr);
    end
  endtask

  task automatic test_async_reset;
    int resp = 0;
    @(negedge clk);
    issue(64'h1_0000_0000, 1'b1, 64'hAA, 8'hFF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (s_cyc !== '0 || s_stb !== '0 || wb_stall !== 1'b0 || s_adr !== '0 || err_count !== '0)
    begin
      bad++; $display("FAIL arst got=%b/%b/%b/%0h/%0d exp=0", s_cyc, s_stb, wb_stall, s_adr,
                      err_count);
    end
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    rst = 1'b0;
    s_ack = 4'b0010;
    repeat (4) begin
      @(negedge clk);
      if (wb_ack || wb_err) resp++;
    end
    s_ack = '0;
    total++;
    if (resp != 0) begin
      bad++; $display("FAIL arst_resp got=%0d exp=0", resp);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_stall_write();
    test_miss();
    test_timeout();
    test_overlap();
    test_abort();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
